// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave with configurable data-phase wait states
// and a two-cycle ERROR response for misaligned or unsupported transfer sizes.
module ahb_sram_slave #(
    parameter int WAIT_STATES = 0,
    parameter int DEPTH       = 64
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [7:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [1:0] WS    = 2'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       cnt, cnt_nxt;

    logic [7:0]       addr_p0;
    logic             write_p0;
    logic [2:0]       size_p0;
    logic             vld_p0;

    logic [31:0]      mem [DEPTH];

    logic             hready_int;
    logic             resp_int;
    logic             accept;
    logic             acc_err;
    logic             done_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [3:0]       lane_en_p0;
    logic             unused_ok;

    // Misaligned halfword/word or any size above a word is answered with ERROR.
    function automatic logic size_err(input logic [2:0] size, input logic [1:0] a);
        logic e;
        case (size)
            3'd0:    e = 1'b0;
            3'd1:    e = a[0];
            3'd2:    e = |a;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] en;
        case (size)
            3'd0:    en = 4'b0001 << a;
            3'd1:    en = a[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    assign hready_int = (state == S_WAIT) ? (cnt == 2'd0) : (state != S_ERR1);
    assign resp_int   = (state == S_ERR1) || (state == S_ERR2);

    // Gating with our own ready keeps a stray HREADY from re-arming mid data phase.
    assign accept  = HSEL & HREADY & HTRANS[1] & hready_int;
    assign acc_err = size_err(HSIZE, HADDR[1:0]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == S_ERR1) begin
            state_nxt = S_ERR2;
        end else if (!hready_int) begin
            cnt_nxt = cnt - 2'd1;
        end else begin
            state_nxt = S_IDLE;
            cnt_nxt   = 2'd0;
            if (accept) begin
                if (acc_err) begin
                    state_nxt = S_ERR1;
                end else if (WS != 2'd0) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WS;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---- address phase -> data phase (p0) ----
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            vld_p0   <= 1'b0;
            addr_p0  <= 8'd0;
            write_p0 <= 1'b0;
            size_p0  <= 3'd0;
        end else if (hready_int) begin
            vld_p0 <= accept & ~acc_err;
            if (accept) begin
                addr_p0  <= HADDR;
                write_p0 <= HWRITE;
                size_p0  <= HSIZE;
            end
        end
    end

    assign done_p0    = vld_p0 & hready_int;
    assign idx_p0     = addr_p0[IDX_W+1:2];
    assign lane_en_p0 = lanes(size_p0, addr_p0[1:0]);

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge HCLK) begin
        if (done_p0 && write_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en_p0[i]) begin
                    mem[idx_p0][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = (done_p0 && !write_p0) ? mem[idx_p0] : 32'd0;
    assign HREADYOUT = hready_int;
    assign HRESP     = resp_int;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a zero-wait instance driven from a vector
// table and a two-wait instance exercised with hand-written sequences.
module tb_ahb_sram_slave;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BS = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic        hsel0, hsel2;
    logic [7:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'd0;
    logic        hmastlock = 1'b0;
    logic [31:0] hrdata0, hrdata2;
    logic        hrdyout0, hrdyout2, hresp0, hresp2;

    int checks = 0;
    int passed = 0;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.WAIT_STATES(0), .DEPTH(64)) u_dut0 (
        .HCLK(hclk), .HRESET(hreset_n), .HSEL(hsel0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
        .HREADY(hrdyout0), .HRDATA(hrdata0), .HREADYOUT(hrdyout0), .HRESP(hresp0)
    );

    ahb_sram_slave #(.WAIT_STATES(2), .DEPTH(64)) u_dut2 (
        .HCLK(hclk), .HRESET(hreset_n), .HSEL(hsel2), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
        .HREADY(hrdyout2), .HRDATA(hrdata2), .HREADYOUT(hrdyout2), .HRESP(hresp2)
    );

    function automatic vec_t mk(input logic s, input logic [1:0] t, input logic w,
                                input logic [2:0] sz, input logic [7:0] a,
                                input logic [31:0] d, input logic r, input logic rs,
                                input logic [31:0] rd);
        vec_t v;
        v.sel = s; v.trans = t; v.wr = w; v.size = sz; v.addr = a;
        v.wdata = d; v.rdy = r; v.resp = rs; v.rdata = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got rdy=%0b resp=%0b rdata=%08h, expected rdy=%0b resp=%0b rdata=%08h",
                     name, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    // One bus cycle: drive after the falling edge, sample outputs 1ns later.
    task automatic cyc(input bit use2, input string name, input vec_t v);
        @(negedge hclk);
        hsel0  = use2 ? 1'b0 : v.sel;
        hsel2  = use2 ? v.sel : 1'b0;
        htrans = v.trans;
        hwrite = v.wr;
        hsize  = v.size;
        haddr  = v.addr;
        hwdata = v.wdata;
        #1;
        if (use2) check(name, {hrdyout2, hresp2, hrdata2}, {v.rdy, v.resp, v.rdata});
        else      check(name, {hrdyout0, hresp0, hrdata0}, {v.rdy, v.resp, v.rdata});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [$];

        tbl.push_back(mk(1, NS, 1, 3'd2, 8'h10, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, NS, 0, 3'd2, 8'h10, 32'hDEADBEEF, 1, 0, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, NS, 1, 3'd2, 8'h10, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, NS, 1, 3'd0, 8'h11, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, NS, 0, 3'd2, 8'h10, 32'h1122AA44, 1, 0, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'h0000AA00));
        tbl.push_back(mk(1, NS, 0, 3'd2, 8'h02, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, NS, 1, 3'd2, 8'h10, 32'hFFFFFFFF, 0, 1, 32'h0));
        tbl.push_back(mk(1, NS, 0, 3'd2, 8'h10, 32'hFFFFFFFF, 1, 1, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'hFFFFFFFF, 1, 0, 32'h0000AA00));
        tbl.push_back(mk(1, NS, 1, 3'd2, 8'h20, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, SQ, 1, 3'd2, 8'h24, 32'h12345678, 1, 0, 32'h0));
        tbl.push_back(mk(1, NS, 0, 3'd2, 8'h20, 32'h9ABCDEF0, 1, 0, 32'h0));
        tbl.push_back(mk(1, SQ, 0, 3'd2, 8'h24, 32'h0,        1, 0, 32'h12345678));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'h9ABCDEF0));
        tbl.push_back(mk(1, NS, 1, 3'd1, 8'h26, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, NS, 0, 3'd2, 8'h24, 32'hBEEF1111, 1, 0, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'hBEEFDEF0));
        tbl.push_back(mk(1, NS, 1, 3'd1, 8'h21, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'hFFFFFFFF, 0, 1, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'hFFFFFFFF, 1, 1, 32'h0));
        tbl.push_back(mk(1, NS, 1, 3'd3, 8'h20, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'hFFFFFFFF, 0, 1, 32'h0));
        tbl.push_back(mk(1, NS, 0, 3'd2, 8'h20, 32'hFFFFFFFF, 1, 1, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'h12345678));
        tbl.push_back(mk(0, NS, 1, 3'd2, 8'h20, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, BS, 1, 3'd2, 8'h20, 32'hFFFFFFFF, 1, 0, 32'h0));
        tbl.push_back(mk(1, NS, 0, 3'd2, 8'h20, 32'hFFFFFFFF, 1, 0, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'h12345678));
        tbl.push_back(mk(1, NS, 0, 3'd0, 8'h27, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'hBEEFDEF0));

        hreset_n = 1'b0;
        hsel0 = 1'b0; hsel2 = 1'b0; htrans = ID; hwrite = 1'b0;
        hsize = 3'd0; haddr = 8'h00; hwdata = 32'h0;
        @(posedge hclk);
        #1;
        check("reset_dut0", {hrdyout0, hresp0, hrdata0}, {1'b1, 1'b0, 32'h0});
        check("reset_dut2", {hrdyout2, hresp2, hrdata2}, {1'b1, 1'b0, 32'h0});
        @(negedge hclk);
        hreset_n = 1'b1;

        foreach (tbl[i]) cyc(1'b0, $sformatf("vec%0d", i), tbl[i]);

        // Two wait states: write then pipelined read of the same word.
        cyc(1'b1, "ws_wr_addr",  mk(1, NS, 1, 3'd2, 8'h30, 32'h0,        1, 0, 32'h0));
        cyc(1'b1, "ws_wr_wait1", mk(1, ID, 0, 3'd0, 8'h00, 32'hCAFEF00D, 0, 0, 32'h0));
        cyc(1'b1, "ws_wr_wait2", mk(1, ID, 0, 3'd0, 8'h00, 32'hCAFEF00D, 0, 0, 32'h0));
        cyc(1'b1, "ws_wr_done",  mk(1, NS, 0, 3'd2, 8'h30, 32'hCAFEF00D, 1, 0, 32'h0));
        cyc(1'b1, "ws_rd_wait1", mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        0, 0, 32'h0));
        cyc(1'b1, "ws_rd_wait2", mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        0, 0, 32'h0));
        cyc(1'b1, "ws_rd_data",  mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'hCAFEF00D));
        cyc(1'b1, "ws_idle",     mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'h0));

        // Errors skip the wait states entirely.
        cyc(1'b1, "ws_err_addr", mk(1, NS, 0, 3'd2, 8'h31, 32'h0,        1, 0, 32'h0));
        cyc(1'b1, "ws_err1",     mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        0, 1, 32'h0));
        cyc(1'b1, "ws_err2",     mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 1, 32'h0));
        cyc(1'b1, "ws_err_done", mk(1, ID, 0, 3'd0, 8'h00, 32'h0,        1, 0, 32'h0));

        // Reset in the middle of a waited write.
        cyc(1'b1, "rst_wr_addr", mk(1, NS, 1, 3'd2, 8'h30, 32'h0,        1, 0, 32'h0));
        cyc(1'b1, "rst_wr_wait", mk(1, ID, 0, 3'd0, 8'h00, 32'h55555555, 0, 0, 32'h0));
        @(negedge hclk);
        hsel2 = 1'b0; htrans = ID;
        #2;
        hreset_n = 1'b0;
        #1;
        check("rst_async", {hrdyout2, hresp2, hrdata2}, {1'b1, 1'b0, 32'h0});
        @(posedge hclk);
        @(posedge hclk);
        #1;
        check("rst_hold", {hrdyout2, hresp2, hrdata2}, {1'b1, 1'b0, 32'h0});
        @(negedge hclk);
        hreset_n = 1'b1;

        cyc(1'b1, "post_rst_addr",  mk(1, NS, 0, 3'd2, 8'h30, 32'h0, 1, 0, 32'h0));
        cyc(1'b1, "post_rst_wait1", mk(1, ID, 0, 3'd0, 8'h00, 32'h0, 0, 0, 32'h0));
        cyc(1'b1, "post_rst_wait2", mk(1, ID, 0, 3'd0, 8'h00, 32'h0, 0, 0, 32'h0));
        cyc(1'b1, "post_rst_data",  mk(1, ID, 0, 3'd0, 8'h00, 32'h0, 1, 0, 32'hCAFEF00D));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
